// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 raster constants and shared widths
package vga_timing_pkg;
   localparam int CNT_W = 12;
   localparam int RGB_W = 24;
   localparam logic [CNT_W-1:0] DEF_H_ACTIVE = 12'd640;
   localparam logic [CNT_W-1:0] DEF_H_FP     = 12'd16;
   localparam logic [CNT_W-1:0] DEF_H_SYNC   = 12'd96;
   localparam logic [CNT_W-1:0] DEF_H_BP     = 12'd48;
   localparam logic [CNT_W-1:0] DEF_V_ACTIVE = 12'd480;
   localparam logic [CNT_W-1:0] DEF_V_FP     = 12'd10;
   localparam logic [CNT_W-1:0] DEF_V_SYNC   = 12'd2;
   localparam logic [CNT_W-1:0] DEF_V_BP     = 12'd33;
   localparam int DEF_RD_LAT = 2;

   function automatic logic [CNT_W-1:0] total(input logic [CNT_W-1:0] a, b, c, d);
      return a + b + c + d;
   endfunction

   localparam logic [CNT_W-1:0] DEF_H_TOTAL = total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
   localparam logic [CNT_W-1:0] DEF_V_TOTAL = total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: fixed-depth shift register with synchronous flush
module vga_sync_delay #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);
   logic [DEPTH-1:0][WIDTH-1:0] sr;

   always_ff @(posedge clk or posedge rst)
      if (rst)
         sr <= '0;
      else if (flush)
         sr <= '0;
      else begin
         sr[0] <= din;
         for (int i = 1; i < DEPTH; i++)
            sr[i] <= sr[i-1];
      end

   assign dout = sr[DEPTH-1];
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: lock-gated VGA raster timing, pixel fetch and aligned DAC pin register
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter logic [CNT_W-1:0] H_ACTIVE = DEF_H_ACTIVE,
   parameter logic [CNT_W-1:0] H_FP     = DEF_H_FP,
   parameter logic [CNT_W-1:0] H_SYNC   = DEF_H_SYNC,
   parameter logic [CNT_W-1:0] H_BP     = DEF_H_BP,
   parameter logic [CNT_W-1:0] V_ACTIVE = DEF_V_ACTIVE,
   parameter logic [CNT_W-1:0] V_FP     = DEF_V_FP,
   parameter logic [CNT_W-1:0] V_SYNC   = DEF_V_SYNC,
   parameter logic [CNT_W-1:0] V_BP     = DEF_V_BP,
   parameter logic             HS_POL   = 1'b0,
   parameter logic             VS_POL   = 1'b0,
   parameter int               RD_LAT   = DEF_RD_LAT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pll_locked,
   output logic             req_valid,
   output logic [CNT_W-1:0] req_x,
   output logic [CNT_W-1:0] req_y,
   input  logic [RGB_W-1:0] rd_data,
   output logic [7:0]       vga_r,
   output logic [7:0]       vga_g,
   output logic [7:0]       vga_b,
   output logic             vga_hs,
   output logic             vga_vs,
   output logic             vga_blank_n,
   output logic             vga_sync_n,
   output logic             frame_start,
   output logic             running
);
   localparam logic [CNT_W-1:0] H_MAX  = total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 12'd1;
   localparam logic [CNT_W-1:0] V_MAX  = total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 12'd1;
   localparam logic [CNT_W-1:0] HS_BEG = H_ACTIVE + H_FP;
   localparam logic [CNT_W-1:0] HS_END = HS_BEG + H_SYNC;
   localparam logic [CNT_W-1:0] VS_BEG = V_ACTIVE + V_FP;
   localparam logic [CNT_W-1:0] VS_END = VS_BEG + V_SYNC;

   logic             lock_meta;
   logic [CNT_W-1:0] h_cnt, v_cnt;
   logic             active, hs_on, vs_on;
   logic [2:0]       d_bits;

   always_ff @(posedge clk or posedge rst)
      if (rst)
         {running, lock_meta} <= 2'b00;
      else
         {running, lock_meta} <= {lock_meta, pll_locked};

   // counters sit at (0,0) whenever unlocked so relock always starts a fresh frame
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (!running) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else begin
         h_cnt <= (h_cnt == H_MAX) ? '0 : h_cnt + 12'd1;
         if (h_cnt == H_MAX)
            v_cnt <= (v_cnt == V_MAX) ? '0 : v_cnt + 12'd1;
      end

   always_comb begin
      active      = running && h_cnt < H_ACTIVE && v_cnt < V_ACTIVE;
      hs_on       = h_cnt >= HS_BEG && h_cnt < HS_END;
      vs_on       = v_cnt >= VS_BEG && v_cnt < VS_END;
      req_valid   = active;
      req_x       = active ? h_cnt : '0;
      req_y       = active ? v_cnt : '0;
      frame_start = running && h_cnt == '0 && v_cnt == '0;
   end

   vga_sync_delay #(.WIDTH(3), .DEPTH(RD_LAT)) u_dly (
      .clk   (clk),
      .rst   (rst),
      .flush (!running),
      .din   ({active, hs_on, vs_on}),
      .dout  (d_bits)
   );

   // pin register sees returned data and delayed timing in the same cycle
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         {vga_r, vga_g, vga_b} <= '0;
         vga_hs      <= !HS_POL;
         vga_vs      <= !VS_POL;
         vga_blank_n <= 1'b0;
      end else begin
         {vga_r, vga_g, vga_b} <= (running && d_bits[2]) ? rd_data : '0;
         vga_hs      <= (running && d_bits[1]) ? HS_POL : !HS_POL;
         vga_vs      <= (running && d_bits[0]) ? VS_POL : !VS_POL;
         vga_blank_n <= running && d_bits[2];
      end

   assign vga_sync_n = 1'b0;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three builds (full raster, reduced raster at latency 1 and 8) against a raster model
`timescale 1ns/1ps
module tb_vga_timing_gen;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pll_locked = 1'b0;
   logic mode_ff = 1'b0;
   always #5 clk = ~clk;

   int   p_ha[3]  = '{640, 16, 16};
   int   p_hf[3]  = '{16, 3, 3};
   int   p_hs[3]  = '{96, 5, 5};
   int   p_hb[3]  = '{48, 4, 4};
   int   p_va[3]  = '{480, 6, 6};
   int   p_vf[3]  = '{10, 2, 2};
   int   p_vs[3]  = '{2, 2, 2};
   int   p_vb[3]  = '{33, 3, 3};
   int   p_lat[3] = '{2, 1, 8};
   logic p_pol[3] = '{1'b0, 1'b0, 1'b1};

   logic        rv[3], fs[3], run[3], hs[3], vs[3], bl[3], sn[3];
   logic [11:0] rx[3], ry[3];
   logic [23:0] rd[3];
   logic [7:0]  r[3], g[3], b[3];
   logic [23:0] pipe[3][9];

   int   n_vec = 0, n_bad = 0;
   int   age = 0;
   logic l1 = 1'b0, l2 = 1'b0, mode_q = 1'b0;

   vga_timing_gen u0 (
      .clk(clk), .rst(rst), .pll_locked(pll_locked), .req_valid(rv[0]), .req_x(rx[0]), .req_y(ry[0]),
      .rd_data(rd[0]), .vga_r(r[0]), .vga_g(g[0]), .vga_b(b[0]), .vga_hs(hs[0]), .vga_vs(vs[0]),
      .vga_blank_n(bl[0]), .vga_sync_n(sn[0]), .frame_start(fs[0]), .running(run[0]));

   vga_timing_gen #(.H_ACTIVE(16), .H_FP(3), .H_SYNC(5), .H_BP(4), .V_ACTIVE(6), .V_FP(2),
                    .V_SYNC(2), .V_BP(3), .RD_LAT(1)) u1 (
      .clk(clk), .rst(rst), .pll_locked(pll_locked), .req_valid(rv[1]), .req_x(rx[1]), .req_y(ry[1]),
      .rd_data(rd[1]), .vga_r(r[1]), .vga_g(g[1]), .vga_b(b[1]), .vga_hs(hs[1]), .vga_vs(vs[1]),
      .vga_blank_n(bl[1]), .vga_sync_n(sn[1]), .frame_start(fs[1]), .running(run[1]));

   vga_timing_gen #(.H_ACTIVE(16), .H_FP(3), .H_SYNC(5), .H_BP(4), .V_ACTIVE(6), .V_FP(2),
                    .V_SYNC(2), .V_BP(3), .HS_POL(1'b1), .VS_POL(1'b1), .RD_LAT(8)) u2 (
      .clk(clk), .rst(rst), .pll_locked(pll_locked), .req_valid(rv[2]), .req_x(rx[2]), .req_y(ry[2]),
      .rd_data(rd[2]), .vga_r(r[2]), .vga_g(g[2]), .vga_b(b[2]), .vga_hs(hs[2]), .vga_vs(vs[2]),
      .vga_blank_n(bl[2]), .vga_sync_n(sn[2]), .frame_start(fs[2]), .running(run[2]));

   function automatic logic [23:0] pat(input logic [11:0] x, input logic [11:0] y);
      return {x, y} ^ 24'h5A5A5A;
   endfunction

   // frame buffer stub: the request of cycle m is on rd_data throughout cycle m+lat
   always_comb
      for (int i = 0; i < 3; i++)
         rd[i] = mode_ff ? 24'hFFFFFF : pipe[i][p_lat[i]];

   // expected outputs from the count of consecutive running cycles (age)
   function automatic logic [54:0] expect_out(input int i, input int age_c, input int age_p,
                                              input logic run_c, input logic mode_p);
      int ht, vt, t, h, v, hp, vp;
      logic act, pact, hs_a, vs_a;
      logic [23:0] rgb;
      ht = p_ha[i] + p_hf[i] + p_hs[i] + p_hb[i];
      vt = p_va[i] + p_vf[i] + p_vs[i] + p_vb[i];
      h = 0; v = 0; act = 1'b0;
      if (age_c > 0) begin
         t = age_c - 1;
         h = t % ht;
         v = (t / ht) % vt;
         act = h < p_ha[i] && v < p_va[i];
      end
      hp = 0; vp = 0; pact = 1'b0; hs_a = 1'b0; vs_a = 1'b0;
      if (age_p > p_lat[i]) begin
         t = age_p - 1 - p_lat[i];
         hp = t % ht;
         vp = (t / ht) % vt;
         pact = hp < p_ha[i] && vp < p_va[i];
         hs_a = hp >= p_ha[i] + p_hf[i] && hp < p_ha[i] + p_hf[i] + p_hs[i];
         vs_a = vp >= p_va[i] + p_vf[i] && vp < p_va[i] + p_vf[i] + p_vs[i];
      end
      rgb = pact ? (mode_p ? 24'hFFFFFF : pat(hp[11:0], vp[11:0])) : 24'h0;
      return {run_c, act, act ? h[11:0] : 12'h0, act ? v[11:0] : 12'h0,
              age_c > 0 && h == 0 && v == 0, rgb,
              hs_a ? p_pol[i] : !p_pol[i], vs_a ? p_pol[i] : !p_pol[i], pact, 1'b0};
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h at %0t", name, got, exp, $time);
      end
   endtask

   initial begin
      logic run_c;
      int age_c;
      logic [54:0] got;
      @(posedge clk);
      forever begin
         @(negedge clk);
         run_c = !rst && l2;
         age_c = run_c ? age + 1 : 0;
         for (int i = 0; i < 3; i++) begin
            got = {run[i], rv[i], rx[i], ry[i], fs[i], r[i], g[i], b[i], hs[i], vs[i], bl[i], sn[i]};
            chk($sformatf("raster%0d", i), 64'(got),
                64'(expect_out(i, age_c, rst ? 0 : age, run_c, mode_q)));
         end
         age = age_c;
         l2 = !rst && l1;
         l1 = !rst && pll_locked;
         mode_q = mode_ff;
         for (int i = 0; i < 3; i++) begin
            for (int j = 8; j > 0; j--) pipe[i][j] = pipe[i][j-1];
            pipe[i][0] = pat(rx[i], ry[i]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_start(input string name);
      int k;
      k = 0;
      @(negedge clk);
      while (!fs[0] && k < 10) begin
         @(negedge clk);
         k++;
      end
      chk(name, 64'(k), 64'd2);
   endtask

   initial begin
      int c_hs0, c_bl0, c_vs1, c_bl1, c_fs1, c_hs2, bad_ff, w;
      c_hs0 = 0; c_bl0 = 0; c_vs1 = 0; c_bl1 = 0; c_fs1 = 0; c_hs2 = 0; bad_ff = 0;
      repeat (3) tick();
      #1;
      chk("reset_pins", 64'({run[0], rv[0], bl[0], hs[0], vs[0], hs[2], vs[2], sn[0], r[0]}),
          64'({1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h0}));
      rst = 1'b0;
      repeat (3) tick();
      pll_locked = 1'b1;
      wait_start("lock_to_frame_start");
      for (int k = 0; k < 1603; k++) begin
         if (k == 0) chk("first_req_xy", 64'({rv[0], rx[0], ry[0]}), 64'({1'b1, 24'h0}));
         if (k == 2) chk("pixel00_lat1", 64'({bl[1], r[1], g[1], b[1]}), 64'({1'b1, 24'h5A5A5A}));
         if (k == 3) chk("pixel00_lat2", 64'({bl[0], r[0], g[0], b[0]}), 64'({1'b1, 24'h5A5A5A}));
         if (k == 8) chk("blank_before_lat8", 64'(bl[2]), 64'd0);
         if (k == 9) chk("pixel00_lat8", 64'({bl[2], r[2], g[2], b[2]}), 64'({1'b1, 24'h5A5A5A}));
         if (k >= 3) begin
            c_hs0 += int'(!hs[0]);
            c_bl0 += int'(bl[0]);
         end
         if (k >= 2 && k < 730) begin
            c_vs1 += int'(!vs[1]);
            c_bl1 += int'(bl[1]);
         end
         if (k < 728) c_fs1 += int'(fs[1]);
         if (k >= 9 && k < 373) c_hs2 += int'(hs[2]);
         @(negedge clk);
      end
      chk("hs_low_2_lines", 64'(c_hs0), 64'd192);
      chk("blank_high_2_lines", 64'(c_bl0), 64'd1280);
      chk("vs_low_2_frames", 64'(c_vs1), 64'd112);
      chk("blank_high_2_frames", 64'(c_bl1), 64'd192);
      chk("frame_starts_2_frames", 64'(c_fs1), 64'd2);
      chk("hs_high_pol1_frame", 64'(c_hs2), 64'd65);
      tick();
      mode_ff = 1'b1;
      repeat (3) @(negedge clk);
      repeat (400) begin
         if (bl[1] ? {r[1], g[1], b[1]} != 24'hFFFFFF : {r[1], g[1], b[1]} != 24'h0) bad_ff++;
         @(negedge clk);
      end
      chk("white_only_when_blank_n", 64'(bad_ff), 64'd0);
      tick();
      mode_ff = 1'b0;
      @(negedge clk);
      w = 0;
      while (!(rv[0] && rx[0] == 12'd100) && w < 2000) begin
         @(negedge clk);
         w++;
      end
      chk("reach_pixel100", 64'(w < 2000), 64'd1);
      tick();
      pll_locked = 1'b0;
      repeat (4) @(negedge clk);
      chk("unlock_idle", 64'({run[0], rv[0], bl[0], hs[0], r[0]}), 64'({4'b0001, 8'h0}));
      repeat (5) tick();
      pll_locked = 1'b1;
      wait_start("relock_frame_start");
      chk("relock_origin", 64'({rv[0], rx[0], ry[0], fs[1], fs[2]}), 64'({1'b1, 24'h0, 2'b11}));
      repeat (50) tick();
      rst = 1'b1;
      #1;
      chk("async_reset", 64'({run[0], rv[0], bl[0], hs[0], hs[2], vs[2], r[0], fs[0]}),
          64'({5'b00010, 1'b0, 8'h0, 1'b0}));
      repeat (3) tick();
      rst = 1'b0;
      wait_start("post_reset_frame_start");
      repeat (400) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
